// File: rtl/sys_mem_responder_if.sv
// SYS bus between the L1 cache (initiator) and the backing word memory
// (responder). Carries one request at a time plus the per-beat ready strobe.
interface sys_mem_responder_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 32
);
  logic                 SYSstrobe;
  logic                 SYSrw;
  logic [ADDRWIDTH-1:0] SYSaddr;
  logic [DATAWIDTH-1:0] SYSdata_in;
  logic                 SYSready;
  logic [DATAWIDTH-1:0] SYSdata_out;

  modport master (
    output SYSstrobe,
    output SYSrw,
    output SYSaddr,
    output SYSdata_in,
    input  SYSready,
    input  SYSdata_out
  );

  modport slave (
    input  SYSstrobe,
    input  SYSrw,
    input  SYSaddr,
    input  SYSdata_in,
    output SYSready,
    output SYSdata_out
  );
endinterface

// File: rtl/sys_mem_responder.sv
// Responder end of the SYS bus: a word memory that answers single-word
// writes and aligned BURSTLEN-word block-refill reads after a fixed access
// latency, pulsing SYSready once per beat. All outputs are registered.
module sys_mem_responder #(
  parameter int DATAWIDTH    = 32,
  parameter int ADDRWIDTH    = 32,
  parameter int MEMADDRWIDTH = 10,
  parameter int LATENCY      = 3,
  parameter int BURSTLEN     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sys_mem_responder_if.slave   sys_if,
  output logic                 busy
);

  localparam int DEPTH = 1 << MEMADDRWIDTH;
  localparam int BW    = (BURSTLEN > 1) ? $clog2(BURSTLEN) : 1;

  localparam logic [BW-1:0]           LAST_BEAT  = BW'(BURSTLEN - 1);
  localparam logic [BW-1:0]           BEAT_ONE   = BW'(1);
  localparam logic [MEMADDRWIDTH-1:0] BLOCK_MASK = MEMADDRWIDTH'(BURSTLEN - 1);
  localparam logic [3:0]              LAT_LOAD   = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_RBURST  = 3'd2,
    ST_WACK    = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              lat_q, lat_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [MEMADDRWIDTH-1:0] widx_q, widx_d;
  logic                    rw_q, rw_d;
  logic [DATAWIDTH-1:0]    wdata_q, wdata_d;
  logic                    ready_q, ready_d;
  logic [DATAWIDTH-1:0]    rdata_q, rdata_d;
  logic                    busy_q, busy_d;

  logic [DATAWIDTH-1:0]    mem_q [0:DEPTH-1];
  logic                    commit_s;
  logic                    mem_we_s;
  logic [MEMADDRWIDTH-1:0] rd_idx_s;

  // Address bits above the word index and the byte offset are ignored by design.
  logic unused_addr_s;
  assign unused_addr_s = ^{sys_if.SYSaddr[ADDRWIDTH-1:MEMADDRWIDTH+2],
                           sys_if.SYSaddr[1:0]};

  // Next-state, beat sequencing and output values for the request FSM.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    widx_d   = widx_q;
    rw_d     = rw_q;
    wdata_d  = wdata_q;
    ready_d  = 1'b0;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sys_if.SYSstrobe) begin
          widx_d  = sys_if.SYSaddr[MEMADDRWIDTH+1:2];
          rw_d    = sys_if.SYSrw;
          wdata_d = sys_if.SYSdata_in;
          lat_d   = LAT_LOAD;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!sys_if.SYSstrobe) begin
          state_d = ST_IDLE;
        end else if (lat_q == 4'd0) begin
          ready_d = 1'b1;
          if (rw_q) begin
            beat_d  = {BW{1'b0}};
            state_d = ST_RBURST;
          end else begin
            commit_s = 1'b1;
            state_d  = ST_WACK;
          end
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      ST_RBURST: begin
        if (!sys_if.SYSstrobe) begin
          state_d = ST_IDLE;
        end else if (beat_q == LAST_BEAT) begin
          state_d = ST_RELEASE;
        end else begin
          beat_d  = beat_q + BEAT_ONE;
          ready_d = 1'b1;
        end
      end
      ST_WACK: begin
        if (!sys_if.SYSstrobe) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!sys_if.SYSstrobe) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Beats walk inside the aligned block; the counter never carries out of it.
    rd_idx_s = (widx_q & ~BLOCK_MASK) | MEMADDRWIDTH'(beat_d);
    if (ready_d && rw_q) begin
      rdata_d = mem_q[rd_idx_s];
    end else begin
      rdata_d = {DATAWIDTH{1'b0}};
    end
    busy_d = (state_d != ST_IDLE);
  end

  // A reset edge must never commit a write that happened to be due.
  assign mem_we_s = commit_s & rst;

  // FSM state and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      lat_q   <= 4'd0;
      beat_q  <= {BW{1'b0}};
      widx_q  <= {MEMADDRWIDTH{1'b0}};
      rw_q    <= 1'b0;
      wdata_q <= {DATAWIDTH{1'b0}};
      ready_q <= 1'b0;
      rdata_q <= {DATAWIDTH{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      widx_q  <= widx_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  // Word memory; contents survive reset, write lands on the ready-raising edge.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[widx_q] <= wdata_q;
    end
  end

  assign sys_if.SYSready    = ready_q;
  assign sys_if.SYSdata_out = rdata_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_sys_mem_responder.sv
// Directed bench for sys_mem_responder: three instances built with
// LATENCY 3, 1 and 7, each driven through its own SYS interface.
module tb_sys_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        strb  [3];
  logic        rw    [3];
  logic [31:0] addr  [3];
  logic [31:0] wd    [3];
  logic        rdy   [3];
  logic [31:0] dout  [3];
  logic        busy  [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rbeat [8];
  int          rlat;
  int          rnb;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sys_mem_responder_if #(.DATAWIDTH(32), .ADDRWIDTH(32)) bus ();
    sys_mem_responder #(
      .DATAWIDTH(32), .ADDRWIDTH(32), .MEMADDRWIDTH(10),
      .LATENCY((g == 0) ? 3 : ((g == 1) ? 1 : 7)), .BURSTLEN(4)
    ) dut (
      .clk    (clk),
      .rst    (rst),
      .sys_if (bus.slave),
      .busy   (busy[g])
    );
    assign bus.SYSstrobe  = strb[g];
    assign bus.SYSrw      = rw[g];
    assign bus.SYSaddr    = addr[g];
    assign bus.SYSdata_in = wd[g];
    assign rdy[g]         = bus.SYSready;
    assign dout[g]        = bus.SYSdata_out;
  end

  // Called at a negedge; returns at a negedge with the instance back in IDLE.
  task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d,
                          output int lat);
    int cnt;
    strb[k] = 1'b1; rw[k] = 1'b0; addr[k] = a; wd[k] = d;
    cnt = -1;
    while (!rdy[k] && cnt < 40) begin
      @(negedge clk);
      cnt++;
      addr[k] = 32'h0000_0FFC;
      wd[k]   = 32'h0BAD_0BAD;
    end
    lat = rdy[k] ? cnt : -1;
    n_checks++;
    if (dout[k] !== 32'h0) begin
      $display("FAIL write_beat_data: got %0h expected 0", dout[k]); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (rdy[k] !== 1'b0 || busy[k] !== 1'b1) begin
      $display("FAIL write_single_pulse: ready=%0b busy=%0b expected ready=0 busy=1",
               rdy[k], busy[k]);
      n_fail++;
    end
    strb[k] = 1'b0;
    @(negedge clk);
  endtask

  // Read burst; abort_after>0 drops strobe after that many beats,
  // hold>0 keeps strobe high that many cycles after the last beat.
  task automatic do_read(input int k, input logic [31:0] a, input int abort_after,
                         input int hold);
    int cnt;
    for (int i = 0; i < 8; i++) rbeat[i] = 32'h0;
    rnb = 0;
    strb[k] = 1'b1; rw[k] = 1'b1; addr[k] = a; wd[k] = 32'h0;
    cnt = -1;
    while (!rdy[k] && cnt < 40) begin
      @(negedge clk);
      cnt++;
      addr[k] = ~a;
    end
    rlat = rdy[k] ? cnt : -1;
    while (rdy[k] && rnb < 8) begin
      rbeat[rnb] = dout[k];
      rnb++;
      if (rnb == abort_after) strb[k] = 1'b0;
      @(negedge clk);
    end
    if (abort_after > 0) begin
      for (int i = 0; i < 4; i++) begin
        if (rdy[k]) rnb++;
        @(negedge clk);
      end
    end else begin
      for (int i = 0; i < hold; i++) begin
        n_checks++;
        if (rdy[k] !== 1'b0 || busy[k] !== 1'b1 || dout[k] !== 32'h0) begin
          $display("FAIL release_hold: ready=%0b busy=%0b data=%0h expected 0 1 0",
                   rdy[k], busy[k], dout[k]);
          n_fail++;
        end
        @(negedge clk);
      end
      strb[k] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      strb[k] = 1'b1; rw[k] = 1'b1; addr[k] = 32'h40; wd[k] = 32'h0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rdy[k] !== 1'b0 || dout[k] !== 32'h0 || busy[k] !== 1'b0) begin
        $display("FAIL reset_outputs[%0d]: ready=%0b data=%0h busy=%0b expected 0 0 0",
                 k, rdy[k], dout[k], busy[k]);
        n_fail++;
      end
      strb[k] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy[0] !== 1'b0) begin
      $display("FAIL reset_no_txn: busy=%0b expected 0", busy[0]); n_fail++;
    end
  endtask

  task automatic test_write_read();
    logic [31:0] exp_b [4];
    int lat;
    exp_b[0] = 32'hA0; exp_b[1] = 32'hA1; exp_b[2] = 32'hA2; exp_b[3] = 32'hA3;
    for (int i = 0; i < 4; i++) begin
      do_write(0, 32'h40 + 32'(4 * i), exp_b[i], lat);
      n_checks++;
      if (lat !== 3) begin
        $display("FAIL write_latency[%0d]: got %0d expected 3", i, lat); n_fail++;
      end
    end
    do_read(0, 32'h48, 0, 0);
    n_checks++;
    if (rlat !== 3 || rnb !== 4) begin
      $display("FAIL read_lat_beats: lat=%0d beats=%0d expected 3 4", rlat, rnb);
      n_fail++;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rbeat[i] !== exp_b[i]) begin
        $display("FAIL read_beat[%0d]: got %0h expected %0h", i, rbeat[i], exp_b[i]);
        n_fail++;
      end
    end
    n_checks++;
    if (busy[0] !== 1'b0) begin
      $display("FAIL read_idle_after: busy=%0b expected 0", busy[0]); n_fail++;
    end
  endtask

  task automatic test_latency();
    int lat;
    do_write(1, 32'h0, 32'h11, lat);
    n_checks++;
    if (lat !== 1) begin
      $display("FAIL lat1_write: got %0d expected 1", lat); n_fail++;
    end
    do_read(1, 32'h0, 0, 0);
    n_checks++;
    if (rlat !== 1 || rnb !== 4 || rbeat[0] !== 32'h11) begin
      $display("FAIL lat1_read: lat=%0d beats=%0d beat0=%0h expected 1 4 11",
               rlat, rnb, rbeat[0]);
      n_fail++;
    end
    do_write(2, 32'h10, 32'h77, lat);
    n_checks++;
    if (lat !== 7) begin
      $display("FAIL lat7_write: got %0d expected 7", lat); n_fail++;
    end
    do_read(2, 32'h10, 0, 0);
    n_checks++;
    if (rlat !== 7 || rnb !== 4 || rbeat[0] !== 32'h77) begin
      $display("FAIL lat7_read: lat=%0d beats=%0d beat0=%0h expected 7 4 77",
               rlat, rnb, rbeat[0]);
      n_fail++;
    end
  endtask

  task automatic test_abort();
    int lat;
    int seen;
    do_write(0, 32'h100, 32'h1234, lat);
    // Aborted write: strobe dropped while still counting latency.
    strb[0] = 1'b1; rw[0] = 1'b0; addr[0] = 32'h100; wd[0] = 32'hDEAD;
    repeat (2) @(negedge clk);
    strb[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rdy[0] !== 1'b0 || busy[0] !== 1'b0) begin
      $display("FAIL abort_write_idle: ready=%0b busy=%0b expected 0 0", rdy[0], busy[0]);
      n_fail++;
    end
    seen = 0;
    repeat (5) begin
      if (rdy[0]) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 0) begin
      $display("FAIL abort_write_ready: got %0d pulses expected 0", seen); n_fail++;
    end
    do_read(0, 32'h100, 0, 0);
    n_checks++;
    if (rbeat[0] !== 32'h1234) begin
      $display("FAIL abort_write_mem: got %0h expected 1234", rbeat[0]); n_fail++;
    end
    // Aborted read after the second beat.
    do_read(0, 32'h40, 2, 0);
    n_checks++;
    if (rnb !== 2 || rbeat[0] !== 32'hA0 || rbeat[1] !== 32'hA1) begin
      $display("FAIL abort_read: beats=%0d b0=%0h b1=%0h expected 2 a0 a1",
               rnb, rbeat[0], rbeat[1]);
      n_fail++;
    end
    n_checks++;
    if (busy[0] !== 1'b0) begin
      $display("FAIL abort_read_idle: busy=%0b expected 0", busy[0]); n_fail++;
    end
  endtask

  task automatic test_wrap();
    int lat;
    do_write(0, 32'h1000, 32'h55, lat);
    do_read(0, 32'h0, 0, 0);
    n_checks++;
    if (rbeat[0] !== 32'h55) begin
      $display("FAIL wrap_beat0: got %0h expected 55", rbeat[0]); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    do_read(0, 32'h44, 0, 5);
    n_checks++;
    if (rlat !== 3 || rnb !== 4 || rbeat[3] !== 32'hA3) begin
      $display("FAIL held_read: lat=%0d beats=%0d b3=%0h expected 3 4 a3",
               rlat, rnb, rbeat[3]);
      n_fail++;
    end
    do_read(0, 32'h4C, 0, 0);
    n_checks++;
    if (rlat !== 3 || rnb !== 4 || rbeat[0] !== 32'hA0 || rbeat[2] !== 32'hA2) begin
      $display("FAIL b2b_read: lat=%0d beats=%0d b0=%0h b2=%0h expected 3 4 a0 a2",
               rlat, rnb, rbeat[0], rbeat[2]);
      n_fail++;
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      strb[k] = 1'b0; rw[k] = 1'b0; addr[k] = 32'h0; wd[k] = 32'h0;
    end
    @(negedge clk);
    test_reset();
    test_write_read();
    test_latency();
    test_abort();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
